// File: rtl/lm32_dtlb_walker_pkg.sv
// Shared definitions for the DTLB refill walker: FSM states, fault codes
// reported to software, and the position of the valid bit in PDE/PTE words.
package lm32_dtlb_walker_pkg;

  typedef enum logic [2:0] {
    WALK_IDLE   = 3'd0,
    WALK_L1     = 3'd1,
    WALK_L2     = 3'd2,
    WALK_UPDATE = 3'd3,
    WALK_FAULT  = 3'd4,
    WALK_DRAIN  = 3'd5
  } walk_state_t;

  localparam logic [1:0] FAULT_NONE = 2'b00;
  localparam logic [1:0] FAULT_PDE  = 2'b01;
  localparam logic [1:0] FAULT_PTE  = 2'b10;
  localparam logic [1:0] FAULT_BUS  = 2'b11;

  localparam int PTE_VALID_BIT = 0;

endpackage

// File: rtl/lm32_dtlb_walker.sv
// Hardware DTLB refill engine. Walks a two-level page table over a
// read-only Wishbone master port and either writes the translation into the
// DTLB (one-cycle update pulse) or reports a fault code for software.
module lm32_dtlb_walker
  import lm32_dtlb_walker_pkg::*;
#(
  parameter int page_size      = 4096,
  parameter int dir_bits       = 10,
  parameter int timeout_cycles = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        walk_req_i,
  input  logic [31:0] walk_vaddr_i,
  input  logic [31:0] ptbr_i,
  input  logic        walk_abort_i,
  output logic        busy_o,
  output logic        tlb_update_o,
  output logic [31:0] tlb_vaddr_o,
  output logic [31:0] tlb_paddr_o,
  output logic        walk_fault_o,
  output logic [1:0]  fault_code_o,
  output logic [31:0] wb_adr_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  localparam int offset_bits = $clog2(page_size);
  localparam int vpn_bits    = 32 - offset_bits;
  localparam int table_bits  = 32 - offset_bits - dir_bits;
  localparam logic [7:0] timeout_max = 8'(timeout_cycles);

  walk_state_t          state;
  logic [vpn_bits-1:0]  vpn_q;
  logic [7:0]           timer;
  logic [7:0]           timer_next;
  logic                 timed_out;
  logic                 entry_valid;
  logic                 access_done;
  logic [31:0]          l1_addr;
  logic [31:0]          l2_addr;
  logic [31:0]          entry_frame;
  logic                 unused_bits;

  // The walker only ever reads, always on full words, and stb follows cyc.
  assign wb_stb_o = wb_cyc_o;
  assign wb_we_o  = 1'b0;
  assign wb_sel_o = 4'hF;

  // Address arithmetic for both table levels (modulo 2^32 by width).
  assign l1_addr     = ptbr_i + (32'(walk_vaddr_i[31 -: dir_bits]) << 2);
  assign entry_frame = {wb_dat_i[31:offset_bits], {offset_bits{1'b0}}};
  assign l2_addr     = entry_frame + (32'(vpn_q[table_bits-1:0]) << 2);
  assign entry_valid = wb_dat_i[PTE_VALID_BIT];

  // Per-access wait counter: saturates instead of wrapping.
  assign timed_out   = (timer == timeout_max);
  assign timer_next  = (timer == 8'hFF) ? timer : timer + 8'd1;
  assign access_done = wb_ack_i | wb_err_i | timed_out;

  // Page offset bits and entry flag bits are don't-cares for the walk.
  assign unused_bits = ^{walk_vaddr_i[offset_bits-1:0], wb_dat_i[offset_bits-1:1]};

  // Walk FSM with all outputs registered; reset drops the bus immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= WALK_IDLE;
      vpn_q        <= '0;
      timer        <= '0;
      busy_o       <= 1'b0;
      tlb_update_o <= 1'b0;
      tlb_vaddr_o  <= '0;
      tlb_paddr_o  <= '0;
      walk_fault_o <= 1'b0;
      fault_code_o <= FAULT_NONE;
      wb_adr_o     <= '0;
      wb_cyc_o     <= 1'b0;
    end else begin
      tlb_update_o <= 1'b0;
      walk_fault_o <= 1'b0;
      case (state)
        WALK_IDLE: begin
          if (walk_req_i) begin
            vpn_q    <= walk_vaddr_i[31:offset_bits];
            wb_adr_o <= l1_addr;
            wb_cyc_o <= 1'b1;
            busy_o   <= 1'b1;
            timer    <= '0;
            state    <= WALK_L1;
          end
        end
        WALK_L1, WALK_L2: begin
          if (walk_abort_i) begin
            // An access ending in the abort cycle needs no drain.
            if (access_done) begin
              wb_cyc_o <= 1'b0;
              busy_o   <= 1'b0;
              state    <= WALK_IDLE;
            end else begin
              timer <= timer_next;
              state <= WALK_DRAIN;
            end
          end else if (wb_err_i || timed_out) begin
            wb_cyc_o     <= 1'b0;
            walk_fault_o <= 1'b1;
            fault_code_o <= FAULT_BUS;
            state        <= WALK_FAULT;
          end else if (wb_ack_i) begin
            if (!entry_valid) begin
              wb_cyc_o     <= 1'b0;
              walk_fault_o <= 1'b1;
              fault_code_o <= (state == WALK_L1) ? FAULT_PDE : FAULT_PTE;
              state        <= WALK_FAULT;
            end else if (state == WALK_L1) begin
              wb_adr_o <= l2_addr;
              timer    <= '0;
              state    <= WALK_L2;
            end else begin
              wb_cyc_o     <= 1'b0;
              tlb_update_o <= 1'b1;
              tlb_vaddr_o  <= {vpn_q, {offset_bits{1'b0}}};
              tlb_paddr_o  <= entry_frame;
              state        <= WALK_UPDATE;
            end
          end else begin
            timer <= timer_next;
          end
        end
        WALK_UPDATE, WALK_FAULT: begin
          busy_o <= 1'b0;
          state  <= WALK_IDLE;
        end
        WALK_DRAIN: begin
          if (access_done) begin
            wb_cyc_o <= 1'b0;
            busy_o   <= 1'b0;
            state    <= WALK_IDLE;
          end else begin
            timer <= timer_next;
          end
        end
        default: begin
          wb_cyc_o <= 1'b0;
          busy_o   <= 1'b0;
          state    <= WALK_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lm32_dtlb_walker.sv
// Directed bench for the DTLB walker: successful walk, PDE/PTE faults,
// timeout and bus error, abort with drain, and reset in the middle of a walk.
module tb_lm32_dtlb_walker;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        walk_req_i = 1'b0;
  logic [31:0] walk_vaddr_i = '0;
  logic [31:0] ptbr_i = '0;
  logic        walk_abort_i = 1'b0;
  logic        busy_o, tlb_update_o, walk_fault_o;
  logic [31:0] tlb_vaddr_o, tlb_paddr_o, wb_adr_o;
  logic [1:0]  fault_code_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i, wb_err_i;

  logic        ack_en = 1'b1;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = '0;
  logic [31:0] pde_addr = 32'h0010_0400;
  logic [31:0] pde_val  = 32'h0020_0001;
  logic [31:0] pte_addr = 32'h0020_0014;
  logic [31:0] pte_val  = 32'h0ABC_D001;

  int tests_run = 0;
  int tests_failed = 0;
  int acc_count = 0;
  int upd_count = 0;
  int flt_count = 0;
  int acc0, upd0, flt0;

  lm32_dtlb_walker #(
    .page_size      (4096),
    .dir_bits       (10),
    .timeout_cycles (8)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .walk_req_i   (walk_req_i),
    .walk_vaddr_i (walk_vaddr_i),
    .ptbr_i       (ptbr_i),
    .walk_abort_i (walk_abort_i),
    .busy_o       (busy_o),
    .tlb_update_o (tlb_update_o),
    .tlb_vaddr_o  (tlb_vaddr_o),
    .tlb_paddr_o  (tlb_paddr_o),
    .walk_fault_o (walk_fault_o),
    .fault_code_o (fault_code_o),
    .wb_adr_o     (wb_adr_o),
    .wb_cyc_o     (wb_cyc_o),
    .wb_stb_o     (wb_stb_o),
    .wb_we_o      (wb_we_o),
    .wb_sel_o     (wb_sel_o),
    .wb_dat_i     (wb_dat_i),
    .wb_ack_i     (wb_ack_i),
    .wb_err_i     (wb_err_i)
  );

  always #5 clk_i = ~clk_i;

  // Zero-wait-state slave holding one PDE and one PTE.
  assign wb_ack_i = wb_cyc_o && ack_en;
  assign wb_err_i = wb_cyc_o && err_en && (wb_adr_o == err_addr);
  assign wb_dat_i = (wb_adr_o == pde_addr) ? pde_val :
                    (wb_adr_o == pte_addr) ? pte_val : 32'hDEAD_BEE0;

  // Count completed bus accesses and result pulses.
  always @(posedge clk_i) begin
    if (wb_cyc_o && (wb_ack_i || wb_err_i)) acc_count <= acc_count + 1;
    if (tlb_update_o) upd_count <= upd_count + 1;
    if (walk_fault_o) flt_count <= flt_count + 1;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] va, input logic [31:0] pt);
    walk_req_i   = 1'b1;
    walk_vaddr_i = va;
    ptbr_i       = pt;
    acc0 = acc_count;
    upd0 = upd_count;
    flt0 = flt_count;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    // Reset state
    #3;
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_cyc", 32'(wb_cyc_o), 32'd0);
    checkOutput("rst_sel", 32'(wb_sel_o), 32'hF);
    checkOutput("rst_code", 32'(fault_code_o), 32'd0);
    checkOutput("rst_adr", wb_adr_o, 32'd0);
    #8 rst_i = 1'b0;
    tick();

    // Abort in idle is ignored
    walk_abort_i = 1'b1;
    tick();
    walk_abort_i = 1'b0;
    checkOutput("idle_abort_busy", 32'(busy_o), 32'd0);

    // 1: successful walk, zero wait states
    applyStimulus(32'h4000_5123, 32'h0010_0000);
    tick();
    walk_req_i = 1'b0;
    checkOutput("t1_l1_adr", wb_adr_o, 32'h0010_0400);
    checkOutput("t1_l1_cyc", 32'({wb_cyc_o, wb_stb_o, wb_we_o, busy_o}), 32'b1101);
    tick();
    checkOutput("t1_l2_adr", wb_adr_o, 32'h0020_0014);
    checkOutput("t1_l2_upd", 32'(tlb_update_o), 32'd0);
    tick();
    checkOutput("t1_upd", 32'({tlb_update_o, wb_cyc_o, walk_fault_o}), 32'b100);
    checkOutput("t1_vaddr", tlb_vaddr_o, 32'h4000_5000);
    checkOutput("t1_paddr", tlb_paddr_o, 32'h0ABC_D000);
    tick();
    checkOutput("t1_idle", 32'({tlb_update_o, busy_o}), 32'b00);
    checkOutput("t1_acc", 32'(acc_count - acc0), 32'd2);

    // 2: invalid PDE
    pde_val = 32'h0020_0000;
    applyStimulus(32'h4000_5123, 32'h0010_0000);
    tick();
    walk_req_i = 1'b0;
    tick();
    checkOutput("t2_fault", 32'({walk_fault_o, wb_cyc_o, tlb_update_o}), 32'b100);
    checkOutput("t2_code", 32'(fault_code_o), 32'b01);
    tick();
    checkOutput("t2_pulse_end", 32'({walk_fault_o, busy_o}), 32'b00);
    checkOutput("t2_acc", 32'(acc_count - acc0), 32'd1);
    pde_val = 32'h0020_0001;

    // 4a: slave silent, timeout after 8 waited cycles
    ack_en = 1'b0;
    applyStimulus(32'h4000_5123, 32'h0010_0000);
    tick();
    walk_req_i = 1'b0;
    repeat (8) tick();
    checkOutput("t4_wait", 32'({wb_cyc_o, walk_fault_o}), 32'b10);
    tick();
    checkOutput("t4_timeout", 32'({walk_fault_o, wb_cyc_o}), 32'b10);
    checkOutput("t4_code", 32'(fault_code_o), 32'b11);
    tick();
    ack_en = 1'b1;

    // 3: invalid PTE
    pte_val = 32'h0ABC_D000;
    applyStimulus(32'h4000_5123, 32'h0010_0000);
    tick();
    walk_req_i = 1'b0;
    tick();
    tick();
    checkOutput("t3_fault", 32'(walk_fault_o), 32'd1);
    checkOutput("t3_code", 32'(fault_code_o), 32'b10);
    tick();
    checkOutput("t3_acc", 32'(acc_count - acc0), 32'd2);
    checkOutput("t3_noupd", 32'(upd_count - upd0), 32'd0);
    pte_val = 32'h0ABC_D001;

    // 4b: bus error together with ack on the PTE read
    err_en = 1'b1;
    err_addr = pte_addr;
    applyStimulus(32'h4000_5123, 32'h0010_0000);
    tick();
    walk_req_i = 1'b0;
    tick();
    tick();
    checkOutput("t4b_fault", 32'({walk_fault_o, tlb_update_o}), 32'b10);
    checkOutput("t4b_code", 32'(fault_code_o), 32'b11);
    tick();
    err_en = 1'b0;

    // 5: abort during L2 with a delayed ack
    applyStimulus(32'h4000_5123, 32'h0010_0000);
    tick();
    walk_req_i = 1'b0;
    tick();
    ack_en = 1'b0;
    walk_abort_i = 1'b1;
    tick();
    walk_abort_i = 1'b0;
    checkOutput("t5_drain", 32'({wb_cyc_o, busy_o}), 32'b11);
    repeat (3) tick();
    checkOutput("t5_hold", 32'({wb_cyc_o, busy_o, tlb_update_o, walk_fault_o}), 32'b1100);
    ack_en = 1'b1;
    tick();
    checkOutput("t5_idle", 32'({wb_cyc_o, busy_o}), 32'b00);
    checkOutput("t5_nopulse", 32'((upd_count - upd0) + (flt_count - flt0)), 32'd0);
    applyStimulus(32'h8030_2000, 32'h0010_0000);
    tick();
    walk_req_i = 1'b0;
    checkOutput("t5_newreq", 32'(busy_o), 32'd1);
    checkOutput("t5_new_adr", wb_adr_o, 32'h0010_0800);
    tick();
    tick();
    tick();
    checkOutput("t5_after", 32'(upd_count - upd0), 32'd0);

    // 6: request while busy ignored, then reset mid-L1
    ack_en = 1'b0;
    applyStimulus(32'h4000_5123, 32'h0010_0000);
    tick();
    walk_vaddr_i = 32'hFFC0_0000;
    ptbr_i = 32'h0000_1000;
    tick();
    checkOutput("t6_ignored", wb_adr_o, 32'h0010_0400);
    #2 rst_i = 1'b1;
    #1;
    checkOutput("t6_async", 32'({wb_cyc_o, busy_o, tlb_update_o, walk_fault_o}), 32'b0000);
    checkOutput("t6_code_clr", 32'(fault_code_o), 32'd0);
    walk_req_i = 1'b0;
    #2 rst_i = 1'b0;
    ack_en = 1'b1;
    tick();
    tick();
    checkOutput("t6_nopulse", 32'((upd_count - upd0) + (flt_count - flt0)), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
